// File: rtl/int_rti_sequencer_pkg.sv
// Shared types for the interrupt/RTI sequencer: state encoding, stack word,
// the registered output bundle and the per-state output decode.
package int_rti_sequencer_pkg;

    typedef logic [15:0] stack_word_t;

    localparam stack_word_t SP_RESET_DEFAULT = 16'hFFFF;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        DRAIN   = 3'd1,
        PUSH_HI = 3'd2,
        PUSH_LO = 3'd3,
        VECTOR  = 3'd4,
        RD_LO   = 3'd5,
        WR_LO   = 3'd6,
        WR_HI   = 3'd7
    } seq_state_t;

    typedef struct packed {
        logic        busy;
        logic        INTStall;
        logic        startINT;
        logic        memWrite;
        logic        memRead;
        logic        writePcHigh;
        logic        writePcLow;
        stack_word_t memAddr;
        stack_word_t memDataOut;
    } seq_out_t;

    // Output values for the state being entered; addr/data are ignored by
    // states that do not touch the stack so unused buses stay at zero.
    function automatic seq_out_t state_outputs(input seq_state_t s,
                                               input stack_word_t addr,
                                               input stack_word_t data);
        seq_out_t o;
        o      = '0;
        o.busy = (s != IDLE);
        case (s)
            DRAIN: o.INTStall = 1'b1;
            PUSH_HI, PUSH_LO: begin
                o.INTStall   = 1'b1;
                o.memWrite   = 1'b1;
                o.memAddr    = addr;
                o.memDataOut = data;
            end
            VECTOR: o.startINT = 1'b1;
            RD_LO: begin
                o.memRead = 1'b1;
                o.memAddr = addr;
            end
            WR_LO: begin
                o.writePcLow = 1'b1;
                o.memRead    = 1'b1;
                o.memAddr    = addr;
            end
            WR_HI: o.writePcHigh = 1'b1;
            default: ;
        endcase
        return o;
    endfunction

endpackage

// File: rtl/int_stack_ptr.sv
// 16-bit stack pointer with increment/decrement controls; wraps modulo 2^16.
// Updates on the falling clock edge, matching the PC register.
module int_stack_ptr
    import int_rti_sequencer_pkg::*;
#(
    parameter logic [15:0] SP_RESET = SP_RESET_DEFAULT
) (
    input  logic        clk,
    input  logic        Rst,
    input  logic        inc,
    input  logic        dec,
    output logic [15:0] sp
);

    always_ff @(negedge clk) begin
        if (Rst) begin
            sp <= SP_RESET;
        end else if (inc) begin
            sp <= sp + 16'd1;
        end else if (dec) begin
            sp <= sp - 16'd1;
        end
    end

endmodule

// File: rtl/int_rti_sequencer.sv
// Interrupt entry (drain, push PC, vector) and RTI return (pop PC) sequencer.
// Optional INT_PENDING_EN: remember an intReq that arrives while busy.
module int_rti_sequencer
    import int_rti_sequencer_pkg::*;
#(
    parameter int          DRAIN_CYCLES = 3,
    parameter logic [15:0] SP_RESET     = SP_RESET_DEFAULT
) (
    input  logic        clk,
    input  logic        Rst,
    input  logic        intReq,
    input  logic        rtiReq,
    input  logic        stallIn,
    input  logic [31:0] pcIn,
    input  logic [15:0] memDataIn,
    output logic [15:0] memAddr,
    output logic [15:0] memDataOut,
    output logic        memWrite,
    output logic        memRead,
    output logic        startINT,
    output logic        INTStall,
    output logic        writePcHigh,
    output logic        writePcLow,
    output logic [15:0] returnAddress,
    output logic        busy,
    output logic [2:0]  dbgState,
    output logic [15:0] dbgSp
);

    localparam int CNT_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DRAIN_CYCLES - 1);

    seq_state_t       state;
    seq_out_t         outs;
    logic [CNT_W-1:0] drainCnt;
    logic [31:0]      savedPc;
    stack_word_t      sp;
    logic             spInc;
    logic             spDec;
    logic             intTake;

    // sp moves as each stack access retires; a stalled WR_LO keeps it put.
    assign spInc = (state == RD_LO) || ((state == WR_LO) && !stallIn);
    assign spDec = (state == PUSH_HI) || (state == PUSH_LO);

    int_stack_ptr #(.SP_RESET(SP_RESET)) u_sp (
        .clk (clk),
        .Rst (Rst),
        .inc (spInc),
        .dec (spDec),
        .sp  (sp)
    );

`ifdef INT_PENDING_EN
    logic pending;

    always_ff @(negedge clk) begin
        if (Rst) begin
            pending <= 1'b0;
        end else if ((state == IDLE) && !rtiReq && intTake) begin
            pending <= 1'b0;
        end else if (intReq && ((state != IDLE) || rtiReq)) begin
            pending <= 1'b1;
        end
    end

    assign intTake = intReq | pending;
`else
    assign intTake = intReq;
`endif

    always_ff @(negedge clk) begin
        if (Rst) begin
            state    <= IDLE;
            drainCnt <= '0;
            savedPc  <= '0;
            outs     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (rtiReq) begin
                        state <= RD_LO;
                        outs  <= state_outputs(RD_LO, sp + 16'd1, '0);
                    end else if (intTake) begin
                        state    <= DRAIN;
                        savedPc  <= pcIn;
                        drainCnt <= '0;
                        outs     <= state_outputs(DRAIN, '0, '0);
                    end
                end
                DRAIN: begin
                    drainCnt <= drainCnt + 1'b1;
                    if (drainCnt == CNT_LAST) begin
                        state <= PUSH_HI;
                        outs  <= state_outputs(PUSH_HI, sp, savedPc[31:16]);
                    end
                end
                // sp decrements on this edge, so the low word lands at sp-1.
                PUSH_HI: begin
                    state <= PUSH_LO;
                    outs  <= state_outputs(PUSH_LO, sp - 16'd1, savedPc[15:0]);
                end
                PUSH_LO: begin
                    state <= VECTOR;
                    outs  <= state_outputs(VECTOR, '0, '0);
                end
                VECTOR: begin
                    if (!stallIn) begin
                        state <= IDLE;
                        outs  <= state_outputs(IDLE, '0, '0);
                    end
                end
                // sp increments on this edge, so the high word is at sp+2 now.
                RD_LO: begin
                    state <= WR_LO;
                    outs  <= state_outputs(WR_LO, sp + 16'd2, '0);
                end
                WR_LO: begin
                    if (!stallIn) begin
                        state <= WR_HI;
                        outs  <= state_outputs(WR_HI, '0, '0);
                    end
                end
                WR_HI: begin
                    if (!stallIn) begin
                        state <= IDLE;
                        outs  <= state_outputs(IDLE, '0, '0);
                    end
                end
                default: begin
                    state <= IDLE;
                    outs  <= '0;
                end
            endcase
        end
    end

    // Read data arrives one cycle after the read, so it passes straight through.
    assign returnAddress = (outs.writePcLow | outs.writePcHigh) ? memDataIn : 16'h0000;

    assign memAddr     = outs.memAddr;
    assign memDataOut  = outs.memDataOut;
    assign memWrite    = outs.memWrite;
    assign memRead     = outs.memRead;
    assign startINT    = outs.startINT;
    assign INTStall    = outs.INTStall;
    assign writePcHigh = outs.writePcHigh;
    assign writePcLow  = outs.writePcLow;
    assign busy        = outs.busy;
    assign dbgState    = state;
    assign dbgSp       = sp;

endmodule

// File: tb/tb_int_rti_sequencer.sv
// Directed table-driven bench for int_rti_sequencer, plus a second instance
// with SP_RESET=0 to exercise stack-pointer wrap on push.
module tb_int_rti_sequencer;
    import int_rti_sequencer_pkg::*;

    typedef struct packed {
        logic [2:0]  st;
        logic        busy;
        logic        stall;
        logic        sint;
        logic        mw;
        logic        mr;
        logic        hi;
        logic        lo;
        logic [15:0] addr;
        logic [15:0] dout;
        logic [15:0] ret;
        logic [15:0] sp;
    } obs_t;

    typedef struct {
        logic        intReq;
        logic        rtiReq;
        logic        stallIn;
        logic [31:0] pc;
        obs_t        exp;
        logic        chk0;
        logic [15:0] addr0;
        logic [15:0] sp0;
    } vec_t;

    // Strobe patterns {busy, INTStall, startINT, memWrite, memRead, writePcHigh, writePcLow}
    localparam logic [6:0] F_IDLE  = 7'b0000000;
    localparam logic [6:0] F_DRAIN = 7'b1100000;
    localparam logic [6:0] F_PUSH  = 7'b1101000;
    localparam logic [6:0] F_VEC   = 7'b1010000;
    localparam logic [6:0] F_RD    = 7'b1000100;
    localparam logic [6:0] F_WRLO  = 7'b1000101;
    localparam logic [6:0] F_WRHI  = 7'b1000010;
    localparam logic [31:0] P1 = 32'h0001_0040;
    localparam logic [31:0] P2 = 32'hABCD_1234;

    logic        clk = 1'b0;
    logic        Rst = 1'b1;
    logic        intReq = 1'b0;
    logic        rtiReq = 1'b0;
    logic        stallIn = 1'b0;
    logic [31:0] pcIn = '0;
    logic [15:0] memDataIn = '0;
    logic [15:0] memAddr, memDataOut, returnAddress, dbgSp;
    logic        memWrite, memRead, startINT, INTStall, writePcHigh, writePcLow, busy;
    logic [2:0]  dbgState;
    logic [15:0] memAddr_z, memDataOut_z, returnAddress_z, dbgSp_z;
    logic        memWrite_z, memRead_z, startINT_z, INTStall_z, writePcHigh_z, writePcLow_z, busy_z;
    logic [2:0]  dbgState_z;

    logic [15:0] mem [0:65535];
    vec_t        vecs[$];
    int          n_checks = 0;
    int          n_pass = 0;
    logic        found;

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    int_rti_sequencer #(.DRAIN_CYCLES(3), .SP_RESET(16'hFFFF)) dut (
        .clk(clk), .Rst(Rst), .intReq(intReq), .rtiReq(rtiReq), .stallIn(stallIn),
        .pcIn(pcIn), .memDataIn(memDataIn), .memAddr(memAddr), .memDataOut(memDataOut),
        .memWrite(memWrite), .memRead(memRead), .startINT(startINT), .INTStall(INTStall),
        .writePcHigh(writePcHigh), .writePcLow(writePcLow), .returnAddress(returnAddress),
        .busy(busy), .dbgState(dbgState), .dbgSp(dbgSp)
    );

    int_rti_sequencer #(.DRAIN_CYCLES(3), .SP_RESET(16'h0000)) dut0 (
        .clk(clk), .Rst(Rst), .intReq(intReq), .rtiReq(rtiReq), .stallIn(stallIn),
        .pcIn(pcIn), .memDataIn(memDataIn), .memAddr(memAddr_z), .memDataOut(memDataOut_z),
        .memWrite(memWrite_z), .memRead(memRead_z), .startINT(startINT_z), .INTStall(INTStall_z),
        .writePcHigh(writePcHigh_z), .writePcLow(writePcLow_z), .returnAddress(returnAddress_z),
        .busy(busy_z), .dbgState(dbgState_z), .dbgSp(dbgSp_z)
    );

    // Stack memory: write on the strobe, read data valid the following cycle.
    always @(negedge clk) begin
        if (memWrite) mem[memAddr] <= memDataOut;
        memDataIn <= memRead ? mem[memAddr] : 16'h0000;
    end

    // ---------------- helpers ----------------
    function automatic obs_t mk(input seq_state_t st, input logic [6:0] f, input logic [15:0] addr,
                                input logic [15:0] dout, input logic [15:0] ret, input logic [15:0] sp);
        obs_t o;
        o.st = st;
        {o.busy, o.stall, o.sint, o.mw, o.mr, o.hi, o.lo} = f;
        o.addr = addr;
        o.dout = dout;
        o.ret  = ret;
        o.sp   = sp;
        return o;
    endfunction

    function automatic obs_t sample();
        obs_t o;
        o.st = dbgState;
        {o.busy, o.stall, o.sint, o.mw, o.mr, o.hi, o.lo} =
            {busy, INTStall, startINT, memWrite, memRead, writePcHigh, writePcLow};
        o.addr = memAddr;
        o.dout = memDataOut;
        o.ret  = returnAddress;
        o.sp   = dbgSp;
        return o;
    endfunction

    task automatic add0(input logic i, input logic r, input logic s, input logic [31:0] pc,
                        input obs_t e, input logic c0, input logic [15:0] a0, input logic [15:0] s0);
        vec_t v;
        v.intReq = i; v.rtiReq = r; v.stallIn = s; v.pc = pc; v.exp = e;
        v.chk0 = c0; v.addr0 = a0; v.sp0 = s0;
        vecs.push_back(v);
    endtask

    task automatic add(input logic i, input logic r, input logic s, input logic [31:0] pc, input obs_t e);
        add0(i, r, s, pc, e, 1'b0, 16'h0000, 16'h0000);
    endtask

    // ---------------- scoreboard ----------------
    task automatic check(input string name, input int row, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s row %0d: got %h expected %h", name, row, got, exp);
    endtask

    // ---------------- driver ----------------
    task automatic do_reset();
        @(posedge clk);
        Rst = 1'b1; intReq = 1'b1; rtiReq = 1'b1; stallIn = 1'b0;
        repeat (2) @(posedge clk);
        Rst = 1'b0; intReq = 1'b0; rtiReq = 1'b0;
    endtask

    initial begin
        for (int a = 0; a < 65536; a++) mem[a] = 16'h0000;
        mem[16'h0000] = 16'h5A5A;
        mem[16'h0001] = 16'hC3C3;

        // Interrupt entry then RTI return, no stalls
        add0(1,0,0,P1, mk(IDLE,   F_IDLE,  16'h0000,16'h0000,16'h0000,16'hFFFF), 1'b1, 16'h0000, 16'h0000);
        add (0,0,0,P1, mk(DRAIN,  F_DRAIN, 16'h0000,16'h0000,16'h0000,16'hFFFF));
        add (0,0,0,P1, mk(DRAIN,  F_DRAIN, 16'h0000,16'h0000,16'h0000,16'hFFFF));
        add (0,0,0,P1, mk(DRAIN,  F_DRAIN, 16'h0000,16'h0000,16'h0000,16'hFFFF));
        add0(0,0,0,P1, mk(PUSH_HI,F_PUSH,  16'hFFFF,16'h0001,16'h0000,16'hFFFF), 1'b1, 16'h0000, 16'h0000);
        add0(0,0,0,P1, mk(PUSH_LO,F_PUSH,  16'hFFFE,16'h0040,16'h0000,16'hFFFE), 1'b1, 16'hFFFF, 16'hFFFF);
        add0(0,0,0,P1, mk(VECTOR, F_VEC,   16'h0000,16'h0000,16'h0000,16'hFFFD), 1'b1, 16'h0000, 16'hFFFE);
        add (0,1,0,P1, mk(IDLE,   F_IDLE,  16'h0000,16'h0000,16'h0000,16'hFFFD));
        add (0,0,0,P1, mk(RD_LO,  F_RD,    16'hFFFE,16'h0000,16'h0000,16'hFFFD));
        add (0,0,0,P1, mk(WR_LO,  F_WRLO,  16'hFFFF,16'h0000,16'h0040,16'hFFFE));
        add (0,0,0,P1, mk(WR_HI,  F_WRHI,  16'h0000,16'h0000,16'h0001,16'hFFFF));
        // Second interrupt with stalls in VECTOR, then stalled RTI in WR_LO
        add (1,0,0,P2, mk(IDLE,   F_IDLE,  16'h0000,16'h0000,16'h0000,16'hFFFF));
        add (0,0,0,P2, mk(DRAIN,  F_DRAIN, 16'h0000,16'h0000,16'h0000,16'hFFFF));
        add (0,0,0,P2, mk(DRAIN,  F_DRAIN, 16'h0000,16'h0000,16'h0000,16'hFFFF));
        add (0,0,0,P2, mk(DRAIN,  F_DRAIN, 16'h0000,16'h0000,16'h0000,16'hFFFF));
        add (0,0,0,P2, mk(PUSH_HI,F_PUSH,  16'hFFFF,16'hABCD,16'h0000,16'hFFFF));
        add (0,0,0,P2, mk(PUSH_LO,F_PUSH,  16'hFFFE,16'h1234,16'h0000,16'hFFFE));
        add (0,0,1,P2, mk(VECTOR, F_VEC,   16'h0000,16'h0000,16'h0000,16'hFFFD));
        add (0,0,1,P2, mk(VECTOR, F_VEC,   16'h0000,16'h0000,16'h0000,16'hFFFD));
        add (0,0,1,P2, mk(VECTOR, F_VEC,   16'h0000,16'h0000,16'h0000,16'hFFFD));
        add (0,0,0,P2, mk(VECTOR, F_VEC,   16'h0000,16'h0000,16'h0000,16'hFFFD));
        add (0,1,0,P2, mk(IDLE,   F_IDLE,  16'h0000,16'h0000,16'h0000,16'hFFFD));
        add (0,0,0,P2, mk(RD_LO,  F_RD,    16'hFFFE,16'h0000,16'h0000,16'hFFFD));
        add (0,0,1,P2, mk(WR_LO,  F_WRLO,  16'hFFFF,16'h0000,16'h1234,16'hFFFE));
        add (0,0,1,P2, mk(WR_LO,  F_WRLO,  16'hFFFF,16'h0000,16'hABCD,16'hFFFE));
        add (0,0,1,P2, mk(WR_LO,  F_WRLO,  16'hFFFF,16'h0000,16'hABCD,16'hFFFE));
        add (0,0,0,P2, mk(WR_LO,  F_WRLO,  16'hFFFF,16'h0000,16'hABCD,16'hFFFE));
        add (0,0,0,P2, mk(WR_HI,  F_WRHI,  16'h0000,16'h0000,16'hABCD,16'hFFFF));
        // intReq and rtiReq together: RTI first, reading across the 0xFFFF wrap
        add (1,1,0,P1, mk(IDLE,   F_IDLE,  16'h0000,16'h0000,16'h0000,16'hFFFF));
        add (0,0,0,P1, mk(RD_LO,  F_RD,    16'h0000,16'h0000,16'h0000,16'hFFFF));
        add (0,0,0,P1, mk(WR_LO,  F_WRLO,  16'h0001,16'h0000,16'h5A5A,16'h0000));
        add (0,0,0,P1, mk(WR_HI,  F_WRHI,  16'h0000,16'h0000,16'hC3C3,16'h0001));
        add (0,0,0,P1, mk(IDLE,   F_IDLE,  16'h0000,16'h0000,16'h0000,16'h0001));
`ifdef INT_PENDING_EN
        add (0,0,0,P1, mk(DRAIN,  F_DRAIN, 16'h0000,16'h0000,16'h0000,16'h0001));
`else
        add (0,0,0,P1, mk(IDLE,   F_IDLE,  16'h0000,16'h0000,16'h0000,16'h0001));
`endif

        do_reset();
        for (int i = 0; i < vecs.size(); i++) begin
            @(posedge clk);
            intReq  = vecs[i].intReq;
            rtiReq  = vecs[i].rtiReq;
            stallIn = vecs[i].stallIn;
            pcIn    = vecs[i].pc;
            #1;
            check("outputs", i, 128'(sample()), 128'(vecs[i].exp));
            check("pc_strobe_exclusive", i, 128'($onehot0({startINT, writePcHigh, writePcLow})), 128'd1);
            if (vecs[i].chk0)
                check("sp_reset0_push", i, 128'({memAddr_z, dbgSp_z}), 128'({vecs[i].addr0, vecs[i].sp0}));
        end

        // Reset in the middle of an interrupt push
        do_reset();
        @(posedge clk);
        intReq = 1'b1; pcIn = P1;
        @(posedge clk);
        intReq = 1'b0;
        found = 1'b0;
        for (int k = 0; k < 20; k++) begin
            #1;
            if (memWrite && (memAddr == 16'hFFFE)) begin
                found = 1'b1;
                break;
            end
            @(posedge clk);
        end
        check("push_lo_reached", 100, 128'(found), 128'd1);
        Rst = 1'b1; intReq = 1'b1; rtiReq = 1'b1;
        @(posedge clk);
        #1;
        check("reset_mid_push", 101, 128'(sample()), 128'(mk(IDLE, F_IDLE, 16'h0000, 16'h0000, 16'h0000, 16'hFFFF)));
        check("reset_mid_push_sp0", 101, 128'(dbgSp_z), 128'(16'h0000));
        Rst = 1'b0; intReq = 1'b0; rtiReq = 1'b0;
        @(posedge clk);
        #1;
        check("req_ignored_in_reset", 102, 128'(sample()), 128'(mk(IDLE, F_IDLE, 16'h0000, 16'h0000, 16'h0000, 16'hFFFF)));

        // ---------------- report ----------------
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/int_rti_sequencer.md
INT_RTI_SEQUENCER -- requirements
Module: int_rti_sequencer

Interface
REQ-001 Parameter DRAIN_CYCLES, default 3: pipeline-drain cycles between interrupt acceptance and the stack push.
REQ-002 Parameter SP_RESET, default 16'hFFFF: stack-pointer value after reset.
REQ-003 clk  input  1  clock; all state changes on the negedge, the same edge the PC register uses.
REQ-004 Rst  input  1  reset, synchronous, active-high.
REQ-005 intReq  input  1  one-cycle external interrupt pulse.
REQ-006 rtiReq  input  1  one-cycle pulse when an RTI is decoded.
REQ-007 stallIn  input  1  OR of control-hazard and load-use stalls.
REQ-008 pcIn  input  32  current PC-register value.
REQ-009 memDataIn  input  16  stack read data, valid one cycle after memRead.
REQ-010 memAddr / memDataOut  output  16 / 16  stack address and write data.
REQ-011 memWrite / memRead  output  1 / 1  stack write and read strobes.
REQ-012 startINT / INTStall  output  1 / 1  PC interrupt-vector load and PC hold.
REQ-013 writePcHigh / writePcLow / returnAddress  output  1 / 1 / 16  PC half-word reload.
REQ-014 busy  output  1  high in every state except IDLE.

Function
REQ-015 States: IDLE, DRAIN, PUSH_HI, PUSH_LO, VECTOR, RD_LO, WR_LO, WR_HI.
REQ-016 IDLE: rtiReq=1 -> RD_LO; otherwise intReq=1 -> DRAIN, capture savedPc<=pcIn, clear drainCnt.
REQ-017 IDLE, rtiReq and intReq both 1: RTI wins; the interrupt is handled per REQ-030/031.
REQ-018 DRAIN: INTStall=1; drainCnt increments each cycle; exit to PUSH_HI when drainCnt==DRAIN_CYCLES-1.
REQ-019 PUSH_HI: memWrite=1, memAddr=sp, memDataOut=savedPc[31:16]; sp<=sp-1.
REQ-020 PUSH_LO: memWrite=1, memAddr=sp, memDataOut=savedPc[15:0]; sp<=sp-1.
REQ-021 VECTOR: startINT=1, INTStall=0; hold in VECTOR with startINT asserted while stallIn=1; go to IDLE on the first cycle stallIn=0.
REQ-022 RD_LO: memRead=1, memAddr=sp+1; sp<=sp+1.
REQ-023 WR_LO: writePcLow=1, returnAddress=memDataIn; memRead=1, memAddr=sp+1, sp<=sp+1; hold while stallIn=1, reissuing the same read with no sp change.
REQ-024 WR_HI: writePcHigh=1, returnAddress=memDataIn; hold while stallIn=1; go to IDLE when stallIn=0.
REQ-025 writePcHigh, writePcLow and startINT are mutually exclusive (one-hot or zero) every cycle.
REQ-026 INTStall=1 in DRAIN, PUSH_HI and PUSH_LO; 0 in all other states.
REQ-027 sp arithmetic is 16-bit modulo: 16'h0000-1 = 16'hFFFF; 16'hFFFF+1 = 16'h0000; no error flag.
REQ-028 Every strobe not explicitly asserted in a state is 0; memAddr, memDataOut and returnAddress are 0 when unused.
REQ-029 Interrupt latency, intReq to startINT with no stall: DRAIN_CYCLES+3 cycles.

Configuration
REQ-030 With INT_PENDING_EN defined: an intReq arriving while busy=1 sets a pending flag; IDLE treats pending as intReq; the flag clears on entry to DRAIN.
REQ-031 Without INT_PENDING_EN: an intReq arriving while busy=1 is dropped; no pending flag exists.

Reset
REQ-032 Rst=1 at a clock edge, in any state including mid-sequence: state<=IDLE, sp<=SP_RESET, drainCnt<=0, savedPc<=0, pending<=0, all outputs 0.
REQ-033 An intReq or rtiReq in the same cycle as Rst is ignored.

Structure
REQ-034 A shared package holds the state enum, the 16-bit stack-word type and the SP_RESET default.
REQ-035 One sub-module, int_stack_ptr, holds sp with inc/dec/reset controls; all other logic is in int_rti_sequencer.

Verification
REQ-036 Reset; pcIn=32'h0001_0040, intReq pulse -> INTStall for 5 cycles; writes 16'h0001@FFFF then 16'h0040@FFFE; startINT on cycle 6; sp=FFFD.
REQ-037 Following REQ-036, rtiReq with memory returning 0040 then 0001 -> writePcLow with 16'h0040, then writePcHigh with 16'h0001; sp=FFFF.
REQ-038 stallIn=1 for 3 cycles during VECTOR -> startINT held 4 cycles, then IDLE; repeat in WR_LO -> no extra sp increment.
REQ-039 intReq and rtiReq in the same IDLE cycle -> RTI completes first; then the interrupt is taken with the macro defined, or dropped with it undefined.
REQ-040 SP_RESET=16'h0000, one interrupt -> pushes at 0000 and FFFF; sp=FFFE.
REQ-041 Rst asserted during PUSH_LO -> next cycle IDLE, sp=SP_RESET, all outputs 0.
